// File: rtl/beatmap_stream_sink.sv
// Beatmap stream sink: locks onto the repeating note-position sequence, flags breaks in it,
// and queues beat-captured notes in a first-word-fall-through FIFO for the renderer.
//
// state  | meaning
// SYNC   | waiting for a BASE sample to align the sequence tracker
// LOCKED | tracking; every enabled sample must equal expected_q
module beatmap_stream_sink #(
    parameter int unsigned BASE      = 200,
    parameter int unsigned STEP_LOG2 = 2,
    parameter int unsigned LAST      = 216,
    parameter int unsigned DEPTH     = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       data_en,
    input  logic [7:0]                 data,
    input  logic                       beat_tick,
    input  logic                       clr_flags,
    output logic                       note_valid,
    input  logic                       note_ready,
    output logic [7:0]                 note_pos,
    output logic [2:0]                 note_idx,
    output logic [$clog2(DEPTH):0]     fifo_count,
    output logic                       locked,
    output logic                       seq_err,
    output logic                       overflow
);
    localparam int unsigned AW     = $clog2(DEPTH);
    localparam logic [7:0]  BASE_B = 8'(BASE);
    localparam logic [7:0]  LAST_B = 8'(LAST);
    localparam logic [7:0]  STEP_B = 8'(1 << STEP_LOG2);
    localparam logic [AW:0] FULL_C = (AW + 1)'(DEPTH);

    typedef enum logic {SYNC, LOCKED} state_t;

    state_t        state_q, state_d;
    logic [7:0]    expected_q, expected_d;
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q, count_d;
    logic          seq_err_q, seq_err_d;
    logic          overflow_q, overflow_d;
    logic [10:0]   mem_q [DEPTH];

    logic          in_seq, push_req, pop, full, push_ok;
    logic [7:0]    offset;
    logic [10:0]   head;

    assign offset   = (data - BASE_B) >> STEP_LOG2;
    assign in_seq   = (state_q == LOCKED) && data_en && (data == expected_q);
    assign push_req = in_seq && beat_tick;
    assign full     = (count_q == FULL_C);
    assign pop      = (count_q != '0) && note_ready;
    // A full FIFO can still take a push when the head leaves in the same cycle.
    assign push_ok  = push_req && (!full || pop);

    always_comb begin
        state_d    = state_q;
        expected_d = expected_q;
        seq_err_d  = clr_flags ? 1'b0 : seq_err_q;
        overflow_d = clr_flags ? 1'b0 : overflow_q;
        count_d    = count_q;

        if (data_en) begin
            if (state_q == SYNC) begin
                if (data == BASE_B) begin
                    state_d    = LOCKED;
                    expected_d = BASE_B + STEP_B;
                end
            end else if (data == expected_q) begin
                expected_d = (expected_q == LAST_B) ? BASE_B : expected_q + STEP_B;
            end else begin
                state_d   = SYNC;
                seq_err_d = 1'b1;
            end
        end

        if (push_req && full && !pop) begin
            overflow_d = 1'b1;
        end

        if (push_ok && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push_ok) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= SYNC;
            expected_q <= BASE_B;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            seq_err_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            expected_q <= expected_d;
            count_q    <= count_d;
            seq_err_q  <= seq_err_d;
            overflow_q <= overflow_d;
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
        end
    end

    // Storage is not reset; occupancy gates everything visible.
    always_ff @(posedge clk) begin
        if (!reset && push_ok) begin
            mem_q[wr_ptr_q] <= {data, offset[2:0]};
        end
    end

    assign head       = mem_q[rd_ptr_q];
    assign note_valid = (count_q != '0);
    assign note_pos   = head[10:3];
    assign note_idx   = head[2:0];
    assign fifo_count = count_q;
    assign locked     = (state_q == LOCKED);
    assign seq_err    = seq_err_q;
    assign overflow   = overflow_q;
endmodule
